// File: rtl/aes_shift_rows_pipe.sv
// aes_shift_rows_pipe: pipelined Rijndael ShiftRows/InvShiftRows with valid/ready; macro SHIFT_ROWS_INV_EN adds the inverse path
module aes_shift_rows_pipe #(
    parameter int NB     = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [32*NB-1:0]    in_state,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_state,
    output logic [TAG_W-1:0]    out_tag,
    output logic                busy,
    output logic [15:0]         beat_cnt
);
    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
        $error("aes_shift_rows_pipe: STAGES must be 1..3");
    end

    logic [W-1:0]      w_fwd;
    logic [W-1:0]      w_perm;
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] w_rdy;
    logic [STAGES-1:0] w_up_v;
    logic [W-1:0]      r_d    [STAGES];
    logic [TAG_W-1:0]  r_t    [STAGES];
    logic [W-1:0]      w_up_d [STAGES];
    logic [TAG_W-1:0]  w_up_t [STAGES];
    logic [15:0]       r_cnt;

`ifdef SHIFT_ROWS_INV_EN
    logic [W-1:0] w_inv;
`else
    logic w_unused_inv;
    assign w_unused_inv = in_inv;
`endif

    // Byte k sits at row k%4, column k/4; each output byte is wired to its source byte.
    for (genvar k = 0; k < 4 * NB; k++) begin : g_byte
        localparam int R   = k % 4;
        localparam int C   = k / 4;
        localparam int OFF = (NB == 8 && R >= 2) ? R + 1 : R;
        localparam int FS  = 4 * ((C + OFF) % NB) + R;
        assign w_fwd[W-1-8*k -: 8] = in_state[W-1-8*FS -: 8];
`ifdef SHIFT_ROWS_INV_EN
        localparam int IS  = 4 * ((C + NB - OFF) % NB) + R;
        assign w_inv[W-1-8*k -: 8] = in_state[W-1-8*IS -: 8];
`endif
    end

`ifdef SHIFT_ROWS_INV_EN
    assign w_perm = in_inv ? w_inv : w_fwd;
`else
    assign w_perm = w_fwd;
`endif

    // Upstream view of each stage: the permuted input for stage 1, the previous stage otherwise.
    always_comb begin
        w_up_v    = '0;
        w_up_v[0] = in_valid;
        w_up_d[0] = w_perm;
        w_up_t[0] = in_tag;
        for (int s = 1; s < STAGES; s++) begin
            w_up_v[s] = r_v[s-1];
            w_up_d[s] = r_d[s-1];
            w_up_t[s] = r_t[s-1];
        end
    end

    // A stage can load when downstream accepts or any stage from it to the output is empty.
    always_comb begin
        logic acc;
        acc   = out_ready;
        w_rdy = '0;
        for (int s = STAGES - 1; s >= 0; s--) begin
            acc      = acc | !r_v[s];
            w_rdy[s] = acc;
        end
    end

    // Elastic stage registers and the output handshake counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v   <= '0;
            r_cnt <= '0;
            for (int s = 0; s < STAGES; s++) begin
                r_d[s] <= '0;
                r_t[s] <= '0;
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (w_rdy[s]) begin
                    r_v[s] <= w_up_v[s];
                    if (w_up_v[s]) begin
                        r_d[s] <= w_up_d[s];
                        r_t[s] <= w_up_t[s];
                    end
                end
            end
            if (out_valid && out_ready) r_cnt <= r_cnt + 16'd1;
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[STAGES-1];
    assign out_state = r_d[STAGES-1];
    assign out_tag   = r_t[STAGES-1];
    assign busy      = |r_v;
    assign beat_cnt  = r_cnt;
endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// tb_aes_shift_rows_pipe: directed and random checks of aes_shift_rows_pipe against a row-rotation model
module tb_aes_shift_rows_pipe;
    localparam int NB = 4, ST = 2, TW = 4, W = 128;
`ifdef SHIFT_ROWS_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    logic [W-1:0]  in_state, out_state;
    logic [TW-1:0] in_tag, out_tag;
    logic [15:0]   beat_cnt;

    logic          e_in_valid, e_in_ready, e_in_inv, e_out_valid, e_out_ready, e_busy;
    logic [255:0]  e_in_state, e_out_state;
    logic [TW-1:0] e_in_tag, e_out_tag;
    logic [15:0]   e_beat_cnt;

    aes_shift_rows_pipe #(.NB(NB), .STAGES(ST), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_state(in_state), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_state(out_state), .out_tag(out_tag), .busy(busy), .beat_cnt(beat_cnt)
    );

    aes_shift_rows_pipe #(.NB(8), .STAGES(3), .TAG_W(TW)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_inv(e_in_inv),
        .in_state(e_in_state), .in_tag(e_in_tag), .out_valid(e_out_valid), .out_ready(e_out_ready),
        .out_state(e_out_state), .out_tag(e_out_tag), .busy(e_busy), .beat_cnt(e_beat_cnt)
    );

    int total = 0;
    int bad = 0;
    logic [W+TW-1:0] q[$];
    bit            acc, stall;
    logic [W-1:0]  hold_s;
    logic [TW-1:0] hold_t;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // State as a 4 x nb byte matrix; each row is rotated left one column at a time.
    function automatic logic [255:0] model(input logic [255:0] s, input int nb, input bit inv);
        logic [7:0]   m[4][8];
        logic [7:0]   tmp;
        logic [255:0] o;
        int off, n, top;
        top = 32 * nb;
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) m[r][c] = s[top-1-8*(4*c+r) -: 8];
        for (int r = 0; r < 4; r++) begin
            off = (nb == 8 && r >= 2) ? r + 1 : r;
            n = (inv && INV_EN) ? (nb - off) % nb : off;
            repeat (n) begin
                tmp = m[r][0];
                for (int c = 0; c < nb - 1; c++) m[r][c] = m[r][c+1];
                m[r][nb-1] = tmp;
            end
        end
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) o[top-1-8*(4*c+r) -: 8] = m[r][c];
        return o;
    endfunction

    task automatic step(input bit v, input bit inv, input logic [W-1:0] d, input logic [TW-1:0] t, input bit ordy);
        logic [255:0]    e;
        logic [W+TW-1:0] x;
        @(negedge clk);
        in_valid = v; in_inv = inv; in_state = d; in_tag = t; out_ready = ordy;
        #1;
        if (stall) begin
            check("hold_state", out_state, hold_s);
            check("hold_tag", out_tag, hold_t);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) check("spurious_beat", out_valid, 0);
            else begin
                x = q.pop_front();
                check("stream_state", out_state, x[W-1:0]);
                check("stream_tag", out_tag, x[W+TW-1:W]);
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e = model(d, NB, inv);
            q.push_back({t, e[W-1:0]});
        end
        stall = out_valid && !out_ready;
        hold_s = out_state;
        hold_t = out_tag;
    endtask

    task automatic directed(input bit inv, input logic [W-1:0] din, input logic [W-1:0] exp, input logic [TW-1:0] t);
        @(negedge clk);
        in_valid = 1; in_inv = inv; in_state = din; in_tag = t; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        for (int i = 0; i < ST - 1; i++) begin
            check("latency_early", out_valid, 0);
            @(negedge clk);
        end
        check("latency_valid", out_valid, 1);
        check("directed_state", out_state, exp);
        check("directed_tag", out_tag, t);
    endtask

    initial begin
        logic [255:0] ref8, o8, rnd;
        logic [W-1:0] fexp;
        int sent, n_acc;
        in_valid = 0; in_inv = 0; in_state = '0; in_tag = '0; out_ready = 0;
        e_in_valid = 0; e_in_inv = 0; e_in_state = '0; e_in_tag = '0; e_out_ready = 0;
        stall = 0; acc = 0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_out_state", out_state, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_nb8_valid", e_out_valid, 0);
        @(negedge clk);
        rst_n = 1;
        #1 check("post_rst_in_ready", in_ready, 1);

        directed(0, 128'hd42711aee0bf98f1b8b45de51e415230, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 4'h5);
        @(negedge clk);
        check("fwd_drained", out_valid, 0);
        check("cnt_after_fwd", beat_cnt, 1);
        rnd = model({128'h0, 128'hd4bf5d30e0b452aeb84111f11e2798e5}, NB, 0);
        fexp = INV_EN ? 128'hd42711aee0bf98f1b8b45de51e415230 : rnd[W-1:0];
        directed(1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, fexp, 4'hA);
        @(negedge clk);
        check("cnt_after_inv", beat_cnt, 2);

        for (int k = 0; k < 32; k++) e_in_state[255-8*k -: 8] = k[7:0];
        e_in_valid = 1; e_out_ready = 1; e_in_tag = 4'h3;
        @(negedge clk);
        e_in_valid = 0;
        for (int i = 0; i < 10 && !e_out_valid; i++) @(negedge clk);
        check("nb8_valid", e_out_valid, 1);
        o8 = e_out_state;
        ref8 = model(e_in_state, 8, 0);
        check("nb8_byte1", o8[247 -: 8], 8'h05);
        check("nb8_byte2", o8[239 -: 8], 8'h0e);
        check("nb8_byte3", o8[231 -: 8], 8'h13);
        check("nb8_full", o8, ref8);
        check("nb8_tag", e_out_tag, 4'h3);

        @(negedge clk) rst_n = 0;
        @(negedge clk) rst_n = 1;
        q.delete(); stall = 0;
        sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 100 || q.size() > 0); cyc++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(sent < 100, sent[0], rnd[W-1:0], sent[3:0], 1'($urandom_range(0, 1)));
            if (acc) sent++;
        end
        check("stream_sent", sent, 100);
        check("stream_drained", q.size(), 0);
        step(0, 0, '0, '0, 0);
        check("stream_beat_cnt", beat_cnt, 100);

        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(1, i[0], rnd[W-1:0], i[3:0], 0);
            if (acc) n_acc++;
        end
        check("fill_accepts", n_acc, ST);
        check("fill_in_ready", in_ready, 0);
        check("fill_busy", busy, 1);
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            step(1, i[0], rnd[W-1:0], 4'(i + 8), 1);
            check("flow_in_ready", in_ready, 1);
            check("flow_out_valid", out_valid, 1);
        end
        for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, '0, '0, 1);
        check("flow_drained", q.size(), 0);

        step(1, 0, 128'h0123456789abcdef0011223344556677, 4'h1, 0);
        step(1, 1, 128'hfedcba98765432108899aabbccddeeff, 4'h2, 0);
        check("pre_rst_busy", busy, 1);
        @(posedge clk);
        #2 rst_n = 0;
        in_valid = 0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_beat_cnt", beat_cnt, 0);
        check("mid_rst_out_state", out_state, 0);
        check("mid_rst_out_tag", out_tag, 0);
        q.delete(); stall = 0;
        @(negedge clk) rst_n = 1;
        #1 check("rel_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, '0, '0, 1);
            check("no_stale_beat", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/aes_shift_rows_pipe.md
# aes_shift_rows_pipe

- Pipelined, parametrised Rijndael ShiftRows/InvShiftRows unit with a valid/ready handshake.
- Supports Rijndael block widths Nb = 4, 6 or 8 columns, per-transaction direction select, a sideband tag, and 1–3 elastic register stages.
- Sits between SubBytes and MixColumns in the iterative round datapath; in the decrypt datapath it sits between InvMixColumns and InvSubBytes.

## Interface
Parameters:
- NB, 4, state columns; legal values 4, 6, 8. Data width W = 32*NB.
- STAGES, 2, number of register stages; legal values 1..3.
- TAG_W, 4, sideband tag width, carried unchanged alongside the data.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat present.
- in_ready  output  1  unit can accept a beat this cycle.
- in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows.
- in_state  input  W  input state.
- in_tag  input  TAG_W  sideband.
- out_valid  output  1  output beat present.
- out_ready  input  1  downstream accepts.
- out_state  output  W  permuted state.
- out_tag  output  TAG_W  tag of the beat on out_state.
- busy  output  1  OR of all stage valid bits.
- beat_cnt  output  16  count of completed output handshakes; wraps at 2^16.

## Operation
- Byte layout: byte k = in_state[W-1-8k -: 8]. Layout is column-major, so row r = k mod 4 and column c = k / 4.
- Row offsets:
  - NB = 4 or 6: row r is shifted by r.
  - NB = 8: offsets are {0,1,3,4}.
- Forward transform: out[r][c] = in[r][(c + off(r)) mod NB].
- Inverse transform: out[r][c] = in[r][(c − off(r)) mod NB].
- The permutation is purely combinational and is applied in front of stage 1. Stages 2..STAGES only register data.
- in_inv is sampled together with its beat; the direction can change on every beat.
- Each stage holds data, tag and a valid bit.
  - A stage loads when its upstream side is valid and it is either empty or draining in the same cycle.
  - in_ready = !v1 | (ready into stage 2, or out_ready when STAGES = 1). This is computed combinationally through the chain.
  - in_ready does not depend on in_valid.
- Simultaneous load and drain of one stage: the new beat overwrites the old one in the same edge, with no bubble.
- out_state, out_tag and out_valid come directly from the last stage's registers.
- Once out_valid is asserted, out_state and out_tag stay stable until the handshake completes.
- beat_cnt increments on every cycle where out_valid & out_ready is true.
- Illegal NB or STAGES: elaboration-time error via a generate-time $error.

## Timing
- Latency: a beat accepted at edge n appears on out_valid after edge n+STAGES−1 when no stall occurs. In other words it is visible in the cycle following STAGES accepting edges.
- Throughput: one beat per cycle while out_ready = 1.
- Reset (asserting rst_n low, at any time including mid-transfer):
  - All valid bits, out_valid, busy and beat_cnt clear to 0 immediately and asynchronously.
  - Stage data and tag registers clear to 0, so out_state and out_tag read 0.
  - Any beats in flight are discarded.
- in_ready is 1 during reset deassertion and in the cycle after it.
- Backpressure:
  - out_ready = 0 with the pipe full: in_ready = 0 and no stage changes.
  - Beats are never dropped or duplicated.
- beat_cnt wraps from 16'hFFFF to 0 with no flag.

## Configuration
- Macro SHIFT_ROWS_INV_EN.
- Defined: the inverse permutation is compiled in, and in_inv selects the direction as described above.
- Undefined:
  - Only the forward permutation exists.
  - in_inv is ignored; every beat is treated as in_inv = 0.
  - No inverse mux is synthesised.

## Test plan
- FIPS-197 round 1, NB = 4, STAGES = 2, in_inv = 0, in_state = d42711aee0bf98f1b8b45de51e415230:
  - out_state = d4bf5d30e0b452aeb84111f11e2798e5.
  - out_valid rises exactly 2 cycles after acceptance.
- Same case with in_inv = 1 and input d4bf5d30e0b452aeb84111f11e2798e5:
  - Output = d42711aee0bf98f1b8b45de51e415230.
  - With SHIFT_ROWS_INV_EN undefined, the output equals the forward result of that input instead.
- NB = 8, input bytes 00..1f in order:
  - Output byte 1 = 05 and byte 2 = 0e (offset 3 from column 0 reaches column 3, giving byte 14).
  - Byte 3 = 13 (offset 4 reaches column 4, giving byte 19).
- Stream of 100 beats with alternating in_inv, tags 0..F, and out_ready driven by a random 50% pattern:
  - Outputs arrive in order with matching tags, equal to the reference model.
  - beat_cnt = 100.
  - Data and tag stay stable while out_valid & !out_ready.
- Fill the pipe with out_ready = 0: in_ready falls after STAGES beats are accepted. Then raise out_ready together with in_valid: one beat per cycle flows with no bubble.
- Pulse rst_n low mid-stream while 2 beats are in flight:
  - out_valid, busy, beat_cnt and out_state read 0 immediately.
  - No stale beat appears after reset release.
